pe_block_seq: RTL and testbench



---
 rtl/pe_pkg.sv | 16 +
 rtl/pe_seq_addr_gen.sv | 56 +++++
 rtl/pe_block_seq.sv | 160 ++++++++++++++++
 tb/tb_pe_block_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and widths for the pe_block datapath and its sequencer.
package pe_pkg;

    localparam int WEIGHT_W = 8;
    localparam int SHIFT_W  = 5;
    localparam int KLEN_W   = 8;
    localparam int TILE_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pe_seq_addr_gen.sv
// Tap/tile counters and weight/data read address generation for pe_block_seq.
module pe_seq_addr_gen
    import pe_pkg::*;
#(
    parameter int WADDR_W = 10,
    parameter int DADDR_W = 16
)(
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iLoad,
    input  logic               iStep,
    input  logic [WADDR_W-1:0] iLoadBase,
    input  logic [WADDR_W-1:0] iBase,
    input  logic [KLEN_W-1:0]  iKernelLen,
    input  logic [TILE_W-1:0]  iTileNum,
    output logic [WADDR_W-1:0] oWeightAddr,
    output logic [DADDR_W-1:0] oDataAddr,
    output logic [KLEN_W-1:0]  oTap,
    output logic [TILE_W-1:0]  oTile,
    output logic               oLastTap,
    output logic               oLastTile
);

    always_comb begin
        oLastTap  = (oTap == iKernelLen - KLEN_W'(1));
        oLastTile = (oTile == iTileNum - TILE_W'(1));
    end

    // The tile index stops at T-1 so it still names the final tile during drain.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oTap        <= '0;
            oTile       <= '0;
            oWeightAddr <= '0;
            oDataAddr   <= '0;
        end else if (iLoad) begin
            oTap        <= '0;
            oTile       <= '0;
            oWeightAddr <= iLoadBase;
            oDataAddr   <= '0;
        end else if (iStep) begin
            oDataAddr <= oDataAddr + DADDR_W'(1);
            if (oLastTap) begin
                oTap        <= '0;
                oWeightAddr <= iBase;
                if (!oLastTile) begin
                    oTile <= oTile + TILE_W'(1);
                end
            end else begin
                oTap        <= oTap + KLEN_W'(1);
                oWeightAddr <= oWeightAddr + WADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/pe_block_seq.sv
// Job sequencer for one pe_block: streams kernel weights per tile, issues
// matching data reads, aligns clear-accumulate with the weight path, then drains.
module pe_block_seq
    import pe_pkg::*;
#(
    parameter int ARRAY_NUM = 3,
    parameter int WADDR_W   = 10,
    parameter int DADDR_W   = 16,
    parameter int DRAIN_CYC = 8
)(
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic                 iAbort,
    input  logic [KLEN_W-1:0]    iCfgKernelLen,
    input  logic [TILE_W-1:0]    iCfgTileNum,
    input  logic [WADDR_W-1:0]   iCfgWeightBase,
    input  logic [ARRAY_NUM-2:0] iCfgPassDataLeft,
    input  logic [SHIFT_W-1:0]   iCfgOutputLeftShift,
    input  logic [WEIGHT_W-1:0]  iWeightRdData,
    output logic                 oWeightRdEn,
    output logic [WADDR_W-1:0]   oWeightRdAddr,
    output logic                 oDataRdEn,
    output logic [DADDR_W-1:0]   oDataRdAddr,
    output logic [WEIGHT_W-1:0]  oWeight,
    output logic                 oClearAcc,
    output logic [ARRAY_NUM-2:0] oCfsPassDataLeft,
    output logic [SHIFT_W-1:0]   oCfsOutputLeftShift,
    output logic [TILE_W-1:0]    oTileIdx,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    seq_state_t          state;
    logic                rd_en;
    logic                clr_s1;
    logic [DCNT_W-1:0]   drain_cnt;
    logic [KLEN_W-1:0]   k_len;
    logic [TILE_W-1:0]   t_num;
    logic [WADDR_W-1:0]  w_base;
    logic [KLEN_W-1:0]   tap;
    logic                last_tap;
    logic                last_tile;
    logic                abort_act;
    logic                load;
    logic                step;

    always_comb begin
        abort_act = iAbort && (state != ST_IDLE);
        load      = (state == ST_IDLE) && iStart && !iAbort;
        step      = (state == ST_RUN) && !iAbort;
    end

    assign oWeightRdEn = rd_en;
    assign oDataRdEn   = rd_en;

    pe_seq_addr_gen #(
        .WADDR_W (WADDR_W),
        .DADDR_W (DADDR_W)
    ) u_addr_gen (
        .iClk        (iClk),
        .iRst        (iRst),
        .iLoad       (load),
        .iStep       (step),
        .iLoadBase   (iCfgWeightBase),
        .iBase       (w_base),
        .iKernelLen  (k_len),
        .iTileNum    (t_num),
        .oWeightAddr (oWeightRdAddr),
        .oDataAddr   (oDataRdAddr),
        .oTap        (tap),
        .oTile       (oTileIdx),
        .oLastTap    (last_tap),
        .oLastTile   (last_tile)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state               <= ST_IDLE;
            rd_en               <= 1'b0;
            oBusy               <= 1'b0;
            oDone               <= 1'b0;
            drain_cnt           <= '0;
            k_len               <= '0;
            t_num               <= '0;
            w_base              <= '0;
            oCfsPassDataLeft    <= '0;
            oCfsOutputLeftShift <= '0;
        end else begin
            oDone <= 1'b0;
            if (abort_act) begin
                state <= ST_IDLE;
                rd_en <= 1'b0;
                oBusy <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (iStart) begin
                            k_len               <= iCfgKernelLen;
                            t_num               <= iCfgTileNum;
                            w_base              <= iCfgWeightBase;
                            oCfsPassDataLeft    <= iCfgPassDataLeft;
                            oCfsOutputLeftShift <= iCfgOutputLeftShift;
                            oBusy               <= 1'b1;
                            drain_cnt           <= '0;
                            if (iCfgKernelLen == '0 || iCfgTileNum == '0) begin
                                state <= ST_DONE;
                                oDone <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                                rd_en <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (last_tap && last_tile) begin
                            state     <= ST_DRAIN;
                            rd_en     <= 1'b0;
                            drain_cnt <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt == DCNT_W'(DRAIN_CYC - 1)) begin
                            state <= ST_DONE;
                            oDone <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DCNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        oBusy <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Two clear stages match read issue -> buffer data -> oWeight register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oWeight   <= '0;
            clr_s1    <= 1'b0;
            oClearAcc <= 1'b0;
        end else begin
            oWeight <= iWeightRdData;
            if (abort_act) begin
                clr_s1    <= 1'b0;
                oClearAcc <= 1'b0;
            end else begin
                clr_s1    <= rd_en && (tap == '0);
                oClearAcc <= clr_s1;
            end
        end
    end

endmodule

// File: tb/tb_pe_block_seq.sv
// Directed bench for pe_block_seq: table of jobs checked cycle by cycle against
// a linear-index model, plus abort, async reset and address-wrap sequences.
module tb_pe_block_seq;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic        iAbort;
    logic [7:0]  iCfgKernelLen;
    logic [15:0] iCfgTileNum;
    logic [9:0]  iCfgWeightBase;
    logic [1:0]  iCfgPassDataLeft;
    logic [4:0]  iCfgOutputLeftShift;
    logic [7:0]  iWeightRdData = '0;
    logic        oWeightRdEn;
    logic [9:0]  oWeightRdAddr;
    logic        oDataRdEn;
    logic [15:0] oDataRdAddr;
    logic [7:0]  oWeight;
    logic        oClearAcc;
    logic [1:0]  oCfsPassDataLeft;
    logic [4:0]  oCfsOutputLeftShift;
    logic [15:0] oTileIdx;
    logic        oBusy;
    logic        oDone;

    always #5 iClk = ~iClk;

    pe_block_seq #(
        .ARRAY_NUM (3),
        .WADDR_W   (10),
        .DADDR_W   (16),
        .DRAIN_CYC (8)
    ) dut (
        .iClk                (iClk),
        .iRst                (iRst),
        .iStart              (iStart),
        .iAbort              (iAbort),
        .iCfgKernelLen       (iCfgKernelLen),
        .iCfgTileNum         (iCfgTileNum),
        .iCfgWeightBase      (iCfgWeightBase),
        .iCfgPassDataLeft    (iCfgPassDataLeft),
        .iCfgOutputLeftShift (iCfgOutputLeftShift),
        .iWeightRdData       (iWeightRdData),
        .oWeightRdEn         (oWeightRdEn),
        .oWeightRdAddr       (oWeightRdAddr),
        .oDataRdEn           (oDataRdEn),
        .oDataRdAddr         (oDataRdAddr),
        .oWeight             (oWeight),
        .oClearAcc           (oClearAcc),
        .oCfsPassDataLeft    (oCfsPassDataLeft),
        .oCfsOutputLeftShift (oCfsOutputLeftShift),
        .oTileIdx            (oTileIdx),
        .oBusy               (oBusy),
        .oDone               (oDone)
    );

    // Weight buffer with 1-cycle read latency; contents are a fixed address hash.
    always @(posedge iClk) begin
        if (oWeightRdEn) iWeightRdData <= oWeightRdAddr[7:0] ^ 8'h5A;
    end

    typedef struct {
        int unsigned k;
        int unsigned t;
        logic [9:0]  base;
        logic [1:0]  pass;
        logic [4:0]  shift;
        int unsigned done_cyc;
        int unsigned restart_cyc;
    } job_t;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
        cyc++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rden"},  32'(oWeightRdEn), 0);
        chk({tag, "_drden"}, 32'(oDataRdEn), 0);
        chk({tag, "_waddr"}, 32'(oWeightRdAddr), 0);
        chk({tag, "_daddr"}, 32'(oDataRdAddr), 0);
        chk({tag, "_weight"}, 32'(oWeight), 0);
        chk({tag, "_clr"},   32'(oClearAcc), 0);
        chk({tag, "_pass"},  32'(oCfsPassDataLeft), 0);
        chk({tag, "_shift"}, 32'(oCfsOutputLeftShift), 0);
        chk({tag, "_tile"},  32'(oTileIdx), 0);
        chk({tag, "_busy"},  32'(oBusy), 0);
        chk({tag, "_done"},  32'(oDone), 0);
    endtask

    task automatic start_job(input int unsigned k, input int unsigned t, input logic [9:0] base,
                             input logic [1:0] pass, input logic [4:0] shift);
        iCfgKernelLen       = 8'(k);
        iCfgTileNum         = 16'(t);
        iCfgWeightBase      = base;
        iCfgPassDataLeft    = pass;
        iCfgOutputLeftShift = shift;
        iStart              = 1'b1;
        cyc                 = 0;
        tick();
        iStart = 1'b0;
    endtask

    // Expected behaviour from read index idx = cycle-1: tap idx%K, tile idx/K.
    task automatic run_job(input job_t j);
        int unsigned kt;
        int unsigned idx;
        logic [9:0]  wa;
        logic        exp_clr;
        kt = j.k * j.t;
        start_job(j.k, j.t, j.base, j.pass, j.shift);
        while (cyc <= j.done_cyc + 1) begin
            chk("rden",  32'(oWeightRdEn), 32'(cyc <= kt));
            chk("drden", 32'(oDataRdEn),   32'(cyc <= kt));
            if (cyc <= kt) begin
                idx = cyc - 1;
                wa  = j.base + 10'(idx % j.k);
                chk("waddr", 32'(oWeightRdAddr), 32'(wa));
                chk("daddr", 32'(oDataRdAddr),   idx & 32'hFFFF);
                chk("tile",  32'(oTileIdx),      idx / j.k);
            end
            exp_clr = 1'b0;
            if (kt > 0 && cyc >= 3 && cyc <= kt + 2) begin
                exp_clr = ((cyc - 3) % j.k) == 0;
                wa      = j.base + 10'((cyc - 3) % j.k);
                chk("weight", 32'(oWeight), 32'(wa[7:0] ^ 8'h5A));
            end
            chk("clr",   32'(oClearAcc), 32'(exp_clr));
            chk("done",  32'(oDone),     32'(cyc == j.done_cyc));
            chk("busy",  32'(oBusy),     32'(cyc <= j.done_cyc));
            chk("pass",  32'(oCfsPassDataLeft),    32'(j.pass));
            chk("shift", 32'(oCfsOutputLeftShift), 32'(j.shift));
            if (cyc <= j.done_cyc) begin
                if (cyc == j.restart_cyc) begin
                    iCfgKernelLen       = 8'd1;
                    iCfgTileNum         = 16'd1;
                    iCfgWeightBase      = ~j.base;
                    iCfgPassDataLeft    = ~j.pass;
                    iCfgOutputLeftShift = ~j.shift;
                    iStart              = 1'b1;
                end
                tick();
                iStart = 1'b0;
            end else begin
                break;
            end
        end
    endtask

    job_t jobs[6];
    job_t clean_job;

    initial begin
        // done cycle = K*T + DRAIN_CYC + 1, or 1 for an empty job
        jobs[0] = '{3, 2, 10'h010, 2'b10, 5'd3,  15, 0};
        jobs[1] = '{1, 4, 10'h100, 2'b01, 5'd31, 13, 0};
        jobs[2] = '{0, 5, 10'h020, 2'b11, 5'd1,  1,  0};
        jobs[3] = '{6, 0, 10'h030, 2'b00, 5'd2,  1,  0};
        jobs[4] = '{4, 1, 10'h3FE, 2'b11, 5'd9,  13, 0};
        jobs[5] = '{3, 2, 10'h040, 2'b01, 5'd4,  15, 2};
        clean_job = '{2, 2, 10'h080, 2'b10, 5'd12, 13, 0};

        iRst = 1'b1; iStart = 1'b0; iAbort = 1'b0;
        iCfgKernelLen = '0; iCfgTileNum = '0; iCfgWeightBase = '0;
        iCfgPassDataLeft = '0; iCfgOutputLeftShift = '0;
        repeat (3) tick();
        chk_all_zero("rst_hold");
        iRst = 1'b0;
        tick();
        chk_all_zero("rst_rel");

        for (int i = 0; i < 6; i++) run_job(jobs[i]);

        // Abort during the second tile; the clear for tap 0 of tile 1 is in flight.
        start_job(4, 3, 10'h020, 2'b01, 5'd7);
        while (cyc < 5) begin
            chk("ab_rden", 32'(oWeightRdEn), 1);
            tick();
        end
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        chk("ab_busy", 32'(oBusy), 0);
        chk("ab_rden", 32'(oWeightRdEn), 0);
        chk("ab_drden", 32'(oDataRdEn), 0);
        chk("ab_clr", 32'(oClearAcc), 0);
        chk("ab_pass", 32'(oCfsPassDataLeft), 32'h1);
        chk("ab_shift", 32'(oCfsOutputLeftShift), 32'h7);
        repeat (20) begin
            tick();
            chk("ab_clr_after", 32'(oClearAcc), 0);
            chk("ab_done_after", 32'(oDone), 0);
            chk("ab_busy_after", 32'(oBusy), 0);
        end
        run_job(clean_job);

        // Asynchronous reset in the middle of DRAIN (reads end in cycle 2).
        start_job(2, 1, 10'h055, 2'b11, 5'd21);
        while (cyc < 5) tick();
        chk("dr_busy", 32'(oBusy), 1);
        #2 iRst = 1'b1;
        #1 chk_all_zero("rst_mid");
        iRst = 1'b0;
        repeat (12) begin
            tick();
            chk("rst_done_after", 32'(oDone), 0);
            chk("rst_busy_after", 32'(oBusy), 0);
        end

        // Data address wraps at read 65537 (t=257, k=1) with K=255, T=300.
        start_job(255, 300, 10'h005, 2'b00, 5'd0);
        while (cyc < 65536) tick();
        chk("wrap_daddr_last", 32'(oDataRdAddr), 32'hFFFF);
        chk("wrap_waddr_last", 32'(oWeightRdAddr), 32'h005);
        chk("wrap_tile_last", 32'(oTileIdx), 257);
        tick();
        chk("wrap_daddr_0", 32'(oDataRdAddr), 0);
        chk("wrap_waddr_1", 32'(oWeightRdAddr), 32'h006);
        chk("wrap_tile", 32'(oTileIdx), 257);
        chk("wrap_rden", 32'(oWeightRdEn), 1);
        tick();
        chk("wrap_daddr_1", 32'(oDataRdAddr), 1);
        chk("wrap_waddr_2", 32'(oWeightRdAddr), 32'h007);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        chk("wrap_abort_busy", 32'(oBusy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
